rep3_serial_tx: RTL and testbench

//  Serial transmitter for the triple-repetition line code. Each accepted data word is framed
//  (start, data LSB-first, stop) and every frame bit is sent REP times in a row as "chips".
//  The far end recovers each bit by majority vote over its REP chips.

---
 rtl/rep3_serial_tx.sv | 163 ++++++++++++++++
 tb/tb_rep3_serial_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rep3_serial_tx.sv
// Serial transmitter for a repetition line code: start, data LSB-first and stop bits
// are each sent as REP identical chips, every chip held for CLKS_PER_CHIP cycles.
module rep3_serial_tx #(
  parameter int DATA_W        = 8,
  parameter int REP           = 3,
  parameter int CLKS_PER_CHIP = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] DIN,
  input  logic              DIN_VALID,
  output logic              DIN_READY,
  output logic              TXD,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam int DIV_W = (CLKS_PER_CHIP > 1) ? $clog2(CLKS_PER_CHIP) : 1;
  localparam int REP_W = (REP > 1) ? $clog2(REP) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_CHIP - 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

  if ((REP < 1) || ((REP % 2) == 0)) begin : g_bad_rep
    $error("rep3_serial_tx: REP must be odd and >= 1");
  end
  if (CLKS_PER_CHIP < 1) begin : g_bad_cpc
    $error("rep3_serial_tx: CLKS_PER_CHIP must be >= 1");
  end
  if (DATA_W < 1) begin : g_bad_dw
    $error("rep3_serial_tx: DATA_W must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              bit_end_s;

  // Next-state, counter chain and registered-output computation
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    rep_d     = rep_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    bit_end_s = 1'b0;

    if (state_q != S_IDLE) begin
      if (div_q == DIV_MAX) begin
        div_d = {DIV_W{1'b0}};
        if (rep_q == REP_MAX) begin
          rep_d     = {REP_W{1'b0}};
          bit_end_s = 1'b1;
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = {DIV_W{1'b0}};
      rep_d = {REP_W{1'b0}};
    end

    case (state_q)
      S_IDLE: begin
        if (DIN_VALID && ready_q) begin
          state_d = S_START;
          shreg_d = DIN;
          bit_d   = {BIT_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          // Shift so that shreg_d[0] is always the bit being sent next
          shreg_d = shreg_q >> 1;
          if (bit_q == BIT_MAX) begin
            bit_d   = {BIT_W{1'b0}};
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
    done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  // State, counters, shift register and output flops with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      div_q   <= {DIV_W{1'b0}};
      rep_q   <= {REP_W{1'b0}};
      bit_q   <= {BIT_W{1'b0}};
      shreg_q <= {DATA_W{1'b0}};
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign TXD        = txd_q;
  assign BUSY       = busy_q;
  assign DIN_READY  = ready_q;
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Directed bench for rep3_serial_tx: reset, frame waveform tables, hold/ignore,
// slow line, mid-frame reset and majority-vote loopback with chip errors.
module tb_rep3_serial_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready, txd, busy, frame_done;
  logic [7:0] din_slow;
  logic       valid_slow;
  logic       ready_slow, txd_slow, busy_slow, done_slow;

  int n_tests;
  int n_fail;

  typedef struct {
    logic txd;
    logic busy;
    logic ready;
    logic done;
  } vec_t;

  vec_t vecs [0:30];

  rep3_serial_tx #(.DATA_W(8), .REP(3), .CLKS_PER_CHIP(1)) u_dut (
    .CLK(clk), .RST_N(rst_n), .DIN(din), .DIN_VALID(din_valid),
    .DIN_READY(din_ready), .TXD(txd), .BUSY(busy), .FRAME_DONE(frame_done)
  );

  rep3_serial_tx #(.DATA_W(8), .REP(3), .CLKS_PER_CHIP(4)) u_slow (
    .CLK(clk), .RST_N(rst_n), .DIN(din_slow), .DIN_VALID(valid_slow),
    .DIN_READY(ready_slow), .TXD(txd_slow), .BUSY(busy_slow), .FRAME_DONE(done_slow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected chip value of an 8-bit word's default frame at cycle offset idx
  function automatic logic frame_chip(input logic [7:0] w, input int idx);
    int b;
    b = idx / 3;
    if (b == 0) return 1'b0;
    else if (b == 9) return 1'b1;
    else return w[b-1];
  endfunction

  task automatic check_frame(input string name, input logic [7:0] w);
    for (int i = 0; i < 30; i++) begin
      check({name, "_txd"}, {31'd0, txd}, {31'd0, frame_chip(w, i)});
      check({name, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
    check({name, "_done"}, {31'd0, frame_done}, 32'd1);
    check({name, "_ready"}, {31'd0, din_ready}, 32'd1);
  endtask

  initial begin
    logic [29:0] a5_exp;
    logic [29:0] chips;
    logic [9:0]  bits;
    logic [7:0]  w;
    int          flip;
    int          ones;

    n_tests    = 0;
    n_fail     = 0;
    din        = 8'h00;
    din_valid  = 1'b0;
    din_slow   = 8'h00;
    valid_slow = 1'b0;
    rst_n      = 1'b0;

    // 1: reset held with DIN_VALID high
    din       = 8'hFF;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_ready", {31'd0, din_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, frame_done}, 32'd0);
    end
    din_valid = 1'b0;
    rst_n     = 1'b1;
    tick();
    tick();
    check("idle_txd", {31'd0, txd}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // 2: A5 frame against hand-written waveform table
    a5_exp = 30'b000_111000111000000111000111_111;
    for (int i = 0; i < 31; i++) begin
      vecs[i].txd   = (i < 30) ? a5_exp[29-i] : 1'b1;
      vecs[i].busy  = (i < 30);
      vecs[i].ready = (i == 30);
      vecs[i].done  = (i == 30);
    end
    din       = 8'hA5;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din       = 8'h00;
    for (int i = 0; i < 31; i++) begin
      check("a5_txd", {31'd0, txd}, {31'd0, vecs[i].txd});
      check("a5_busy", {31'd0, busy}, {31'd0, vecs[i].busy});
      check("a5_ready", {31'd0, din_ready}, {31'd0, vecs[i].ready});
      check("a5_done", {31'd0, frame_done}, {31'd0, vecs[i].done});
      tick();
    end
    check("a5_done_pulse", {31'd0, frame_done}, 32'd0);
    check("a5_idle", {31'd0, txd}, 32'd1);

    // 3: valid held, DIN changes mid-frame; second word follows directly
    din       = 8'hA5;
    din_valid = 1'b1;
    tick();
    for (int i = 0; i < 30; i++) begin
      if (i == 5) din = 8'h3C;
      check("hold_txd", {31'd0, txd}, {31'd0, frame_chip(8'hA5, i)});
      check("hold_ready", {31'd0, din_ready}, 32'd0);
      tick();
    end
    check("hold_done", {31'd0, frame_done}, 32'd1);
    check("hold_gap_txd", {31'd0, txd}, 32'd1);
    tick();
    din_valid = 1'b0;
    check_frame("second_3c", 8'h3C);
    tick();

    // 4: slow line, four clocks per chip
    din_slow   = 8'h01;
    valid_slow = 1'b1;
    tick();
    valid_slow = 1'b0;
    for (int i = 0; i < 120; i++) begin
      check("slow_txd", {31'd0, txd_slow},
            {31'd0, ((i >= 12 && i < 24) || i >= 108) ? 1'b1 : 1'b0});
      check("slow_done_low", {31'd0, done_slow}, 32'd0);
      tick();
    end
    check("slow_done", {31'd0, done_slow}, 32'd1);
    check("slow_busy", {31'd0, busy_slow}, 32'd0);
    tick();

    // 5: reset in the middle of an A5 frame
    din       = 8'hA5;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_txd", {31'd0, txd}, 32'd1);
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_ready", {31'd0, din_ready}, 32'd1);
    ones = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      if (frame_done !== 1'b0 || txd !== 1'b1) ones++;
    end
    check("mid_no_done", ones, 32'd0);

    // 6: loopback through a majority voter, clean then with one flipped chip per bit
    for (int pass = 0; pass < 2; pass++) begin
      for (int n = 0; n < 256; n++) begin
        w         = 8'($urandom_range(0, 255));
        din       = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
          chips[i] = txd;
          tick();
        end
        check("loop_done", {31'd0, frame_done}, 32'd1);
        for (int b = 0; b < 10; b++) begin
          if (pass == 1) begin
            flip = $urandom_range(0, 2);
            chips[b*3+flip] = ~chips[b*3+flip];
          end
          ones = int'(chips[b*3]) + int'(chips[b*3+1]) + int'(chips[b*3+2]);
          bits[b] = (ones >= 2);
        end
        check(pass == 0 ? "loop_clean" : "loop_flip", {22'd0, bits},
              {22'd0, 1'b1, w, 1'b0});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
